stage_mem: RTL and testbench

- Memory-access stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.
- Consumes the execute-stage pipeline register outputs: ALU result, store data, M, wbi, destination register, and branch/jump flags with the zero flag and target.
- Performs loads and stores over a req/ack handshake to a data memory of variable latency, and stalls the upstream pipeline while an access is pending.
- Resolves branches, and registers the MEM/WB pipeline register for write-back and forwarding.

---
 rtl/stage_mem_pkg.sv | 14 +
 rtl/stage_mem_access_ctrl.sv | 99 +++++++++
 rtl/stage_mem.sv | 83 ++++++++
 tb/tb_stage_mem.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// Shared MIPS pipeline definitions for the memory stage: write-back control bit
// indices, access FSM state encoding and the default access timeout.
package stage_mem_pkg;

    localparam int unsigned WBI_REGWRITE = 1;
    localparam int unsigned WBI_MEMTOREG = 0;
    localparam int unsigned TIMEOUT_DEF  = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/stage_mem_access_ctrl.sv
// Data-memory access controller: req/ack FSM, timeout counter, registered request
// fields, upstream stall and the sticky error flag.
module mem_access_ctrl
    import stage_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              acc,
    input  logic              we_in,
    input  logic [DATA_W-1:0] addr_in,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              stall_c,
    output logic              load_c,
    output logic              done_c,
    output logic              err_o
);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              req_nx, we_nx, err_nx;
    logic [DATA_W-1:0] addr_nx, wdata_nx;
    logic              mis_c, timeout_hit_c;

    assign mis_c         = acc & (addr_in[1:0] != 2'b00);
    assign timeout_hit_c = (state == ST_BUSY) & ~mem_ack & (cnt == CNT_W'(TIMEOUT - 1));

    // Next-state, request fields and handshake status.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        req_nx   = mem_req;
        we_nx    = mem_we;
        addr_nx  = mem_addr;
        wdata_nx = mem_wdata;
        err_nx   = err_o;
        stall_c  = 1'b0;
        load_c   = 1'b0;
        done_c   = 1'b0;
        if (state == ST_IDLE) begin
            if (!acc) begin
                load_c = 1'b1;
            end else if (mis_c) begin
                err_nx = 1'b1;
            end else begin
                stall_c  = 1'b1;
                state_nx = ST_BUSY;
                req_nx   = 1'b1;
                we_nx    = we_in;
                addr_nx  = {addr_in[DATA_W-1:2], 2'b00};
                wdata_nx = wdata_in;
                cnt_nx   = '0;
            end
        end else begin
            cnt_nx = cnt + CNT_W'(1);
            if (mem_ack) begin
                load_c   = 1'b1;
                done_c   = 1'b1;
                state_nx = ST_IDLE;
                req_nx   = 1'b0;
            end else if (timeout_hit_c) begin
                state_nx = ST_IDLE;
                req_nx   = 1'b0;
                err_nx   = 1'b1;
            end else begin
                stall_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_o     <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            mem_req   <= req_nx;
            mem_we    <= we_nx;
            mem_addr  <= addr_nx;
            mem_wdata <= wdata_nx;
            err_o     <= err_nx;
        end
    end

endmodule

// File: rtl/stage_mem.sv
// MIPS memory-access stage: data-memory loads/stores with upstream stall, branch
// resolution and the MEM/WB pipeline register.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned CNT_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] data_b,
    input  logic              M,
    input  logic [1:0]        wbi,
    input  logic [4:0]        regaddr,
    input  logic              is_jump,
    input  logic              branch_eq,
    input  logic              branch_inc,
    input  logic              zero,
    input  logic [DATA_W-1:0] jump_address,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_o,
    output logic              pc_src_o,
    output logic [DATA_W-1:0] pc_target_o,
    output logic [1:0]        wbi_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] alu_out_o,
    output logic [4:0]        regaddr_o,
    output logic              err_o
);

    logic acc_c, load_c, done_c;

    assign acc_c = M | wbi[WBI_MEMTOREG];

    mem_access_ctrl #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_ctrl (
        .clock     (clock),
        .reset     (reset),
        .acc       (acc_c),
        .we_in     (M),
        .addr_in   (alu_out),
        .wdata_in  (data_b),
        .mem_ack   (mem_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .stall_c   (stall_o),
        .load_c    (load_c),
        .done_c    (done_c),
        .err_o     (err_o)
    );

    assign pc_src_o    = is_jump | (branch_eq & zero) | (branch_inc & ~zero);
    assign pc_target_o = jump_address;

    // MEM/WB register; any cycle that does not retire an instruction loads a bubble.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wbi_o       <= 2'b00;
            read_data_o <= '0;
            alu_out_o   <= '0;
            regaddr_o   <= '0;
        end else begin
            wbi_o[WBI_REGWRITE] <= load_c & wbi[WBI_REGWRITE];
            wbi_o[WBI_MEMTOREG] <= load_c & wbi[WBI_MEMTOREG];
            read_data_o         <= (done_c & ~M) ? mem_rdata : '0;
            alu_out_o           <= alu_out;
            regaddr_o           <= regaddr;
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: ALU pass-through, loads/stores with varied ack
// latency, misalignment, timeout, branch resolution and reset mid-access.
module tb_stage_mem;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] alu_out = '0, data_b = '0, jump_address = '0, mem_rdata = '0;
    logic        M = 1'b0, is_jump = 1'b0, branch_eq = 1'b0, branch_inc = 1'b0, zero = 1'b0;
    logic [1:0]  wbi = 2'b00;
    logic [4:0]  regaddr = '0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, stall_o, pc_src_o, err_o;
    logic [31:0] mem_addr, mem_wdata, pc_target_o, read_data_o, alu_out_o;
    logic [1:0]  wbi_o;
    logic [4:0]  regaddr_o;

    int n_checks = 0;
    int n_pass   = 0;
    int stalls, req_cycles;

    stage_mem #(.DATA_W(32), .TIMEOUT(16), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .alu_out(alu_out), .data_b(data_b), .M(M),
        .wbi(wbi), .regaddr(regaddr), .is_jump(is_jump), .branch_eq(branch_eq),
        .branch_inc(branch_inc), .zero(zero), .jump_address(jump_address),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_o(stall_o), .pc_src_o(pc_src_o),
        .pc_target_o(pc_target_o), .wbi_o(wbi_o), .read_data_o(read_data_o),
        .alu_out_o(alu_out_o), .regaddr_o(regaddr_o), .err_o(err_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] d, input logic m,
                          input logic [1:0] w, input logic [4:0] r);
        alu_out = a; data_b = d; M = m; wbi = w; regaddr = r;
    endtask

    // Runs one access from IDLE; ack is raised in loop cycle ack_at (cycle 0 = IDLE).
    task automatic run_access(input int ack_at, input int budget, input logic [31:0] exp_addr,
                              input logic exp_we, input logic [31:0] exp_wdata,
                              output int n_stall, output int n_req);
        bit done = 1'b0;
        n_stall = 0;
        n_req   = 0;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            mem_ack = (cyc == ack_at);
            #1;
            if (stall_o) n_stall++;
            if (mem_req) n_req++;
            if (cyc == 1) begin
                check("mem_addr", mem_addr, exp_addr);
                check("mem_we", 32'(mem_we), 32'(exp_we));
                check("mem_wdata", mem_wdata, exp_wdata);
            end
            tick();
            if (cyc > 0 && !mem_req) done = 1'b1;
        end
        mem_ack = 1'b0;
        check("access_ends", 32'(done), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_wbi_o", 32'(wbi_o), 32'd0);
        check("rst_err_o", 32'(err_o), 32'd0);
        tick();
        reset = 1'b1;

        // ALU op passes straight through
        set_op(32'h10, 32'h0, 1'b0, 2'b10, 5'd5);
        #1 check("alu_stall", 32'(stall_o), 32'd0);
        tick();
        check("alu_wbi_o", 32'(wbi_o), 32'd2);
        check("alu_out_o", alu_out_o, 32'h10);
        check("alu_regaddr_o", 32'(regaddr_o), 32'd5);
        check("alu_req", 32'(mem_req), 32'd0);

        // Load from 0x40, ack 3 cycles after mem_req rises
        set_op(32'h40, 32'h0, 1'b0, 2'b11, 5'd7);
        mem_rdata = 32'hDEADBEEF;
        run_access(4, 30, 32'h40, 1'b0, 32'h0, stalls, req_cycles);
        check("ld_stall_cycles", 32'(stalls), 32'd4);
        check("ld_req_cycles", 32'(req_cycles), 32'd4);
        check("ld_read_data_o", read_data_o, 32'hDEADBEEF);
        check("ld_wbi_o", 32'(wbi_o), 32'd3);
        check("ld_regaddr_o", 32'(regaddr_o), 32'd7);

        // Back-to-back store of 0x1234 to 0x8, ack in the first BUSY cycle
        set_op(32'h8, 32'h1234, 1'b1, 2'b00, 5'd0);
        run_access(1, 30, 32'h8, 1'b1, 32'h1234, stalls, req_cycles);
        check("st_stall_cycles", 32'(stalls), 32'd1);
        check("st_req_cycles", 32'(req_cycles), 32'd1);
        check("st_wbi_o", 32'(wbi_o), 32'd0);
        check("st_read_data_o", read_data_o, 32'd0);
        check("st_err_o", 32'(err_o), 32'd0);

        // Stray ack while IDLE is ignored
        set_op(32'h44, 32'h0, 1'b0, 2'b10, 5'd3);
        mem_ack = 1'b1;
        #1 check("idle_ack_stall", 32'(stall_o), 32'd0);
        tick();
        mem_ack = 1'b0;
        check("idle_ack_req", 32'(mem_req), 32'd0);
        check("idle_ack_wbi_o", 32'(wbi_o), 32'd2);

        // Misaligned load to 0x41
        set_op(32'h41, 32'h0, 1'b0, 2'b11, 5'd9);
        #1 check("mis_stall", 32'(stall_o), 32'd0);
        tick();
        check("mis_req", 32'(mem_req), 32'd0);
        check("mis_err_o", 32'(err_o), 32'd1);
        check("mis_wbi_o", 32'(wbi_o), 32'd0);
        set_op(32'h0, 32'h0, 1'b0, 2'b10, 5'd1);
        tick();
        check("err_sticky", 32'(err_o), 32'd1);
        reset = 1'b0;
        #1 check("err_cleared", 32'(err_o), 32'd0);
        reset = 1'b1;
        tick();

        // Ack coincident with the timeout cycle completes normally
        set_op(32'h30, 32'h0, 1'b0, 2'b11, 5'd4);
        mem_rdata = 32'hCAFEF00D;
        run_access(16, 40, 32'h30, 1'b0, 32'h0, stalls, req_cycles);
        check("ackto_stall_cycles", 32'(stalls), 32'd16);
        check("ackto_err_o", 32'(err_o), 32'd0);
        check("ackto_read_data_o", read_data_o, 32'hCAFEF00D);
        check("ackto_wbi_o", 32'(wbi_o), 32'd3);

        // Ack never arrives: abort after 16 BUSY cycles
        set_op(32'h20, 32'h0, 1'b0, 2'b11, 5'd6);
        run_access(999, 40, 32'h20, 1'b0, 32'h0, stalls, req_cycles);
        check("to_req_cycles", 32'(req_cycles), 32'd16);
        check("to_stall_cycles", 32'(stalls), 32'd16);
        check("to_err_o", 32'(err_o), 32'd1);
        check("to_wbi_o", 32'(wbi_o), 32'd0);
        set_op(32'h0, 32'h0, 1'b0, 2'b00, 5'd0);
        #1 check("to_released", 32'(stall_o), 32'd0);
        reset = 1'b0;
        #1 check("to_err_reset", 32'(err_o), 32'd0);
        reset = 1'b1;
        tick();

        // Branch resolution
        branch_eq = 1'b1; zero = 1'b1; jump_address = 32'h100;
        #1 check("beq_taken", 32'(pc_src_o), 32'd1);
        check("beq_target", pc_target_o, 32'h100);
        branch_eq = 1'b0; branch_inc = 1'b1;
        #1 check("bne_not_taken", 32'(pc_src_o), 32'd0);
        zero = 1'b0;
        #1 check("bne_taken", 32'(pc_src_o), 32'd1);
        branch_inc = 1'b0; is_jump = 1'b1;
        #1 check("jump_taken", 32'(pc_src_o), 32'd1);
        is_jump = 1'b0;
        #1 check("no_branch", 32'(pc_src_o), 32'd0);

        // Reset asserted mid-access; late ack afterwards is ignored
        set_op(32'h40, 32'h0, 1'b0, 2'b11, 5'd8);
        tick();
        check("mid_req_up", 32'(mem_req), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_req", 32'(mem_req), 32'd0);
        check("mid_rst_addr", mem_addr, 32'd0);
        check("mid_rst_alu_out_o", alu_out_o, 32'd0);
        check("mid_rst_regaddr_o", 32'(regaddr_o), 32'd0);
        set_op(32'h14, 32'h0, 1'b0, 2'b10, 5'd2);
        mem_ack = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("late_ack_req", 32'(mem_req), 32'd0);
        check("late_ack_wbi_o", 32'(wbi_o), 32'd2);
        check("late_ack_read_data_o", read_data_o, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
